// File: rtl/div_alu_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer.
// All arithmetic is borrowed from the shared execute-stage ALU.
module div_alu_sequencer #(
    parameter int          XLEN      = 32,
    parameter logic [3:0]  ALUFN_ADD = 4'b0000,
    parameter logic [3:0]  ALUFN_SUB = 4'b0001
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            alu_req,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_alufn,
    input  logic [XLEN-1:0] alu_r,
    input  logic            alu_cf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_DIV,
        S_SIGN,
        S_DONE
    } state_e;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
    localparam logic [4:0]      LAST    = 5'(XLEN-1);

    state_e          state_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dsr_q;
    logic [4:0]      cnt_q;
    logic            negq_q;
    logic            negr_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            in_signed;
    logic [XLEN-1:0] sh;
    logic            acc;
    logic [XLEN-1:0] sel_v;
    logic            sel_neg;

    assign in_signed = ~op[0];
    assign sh        = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    // A set top bit means the 33-bit partial already exceeds dsr.
    assign acc       = alu_cf | rem_q[XLEN-1];
    assign sel_v     = op_q[1] ? rem_q : quo_q;
    assign sel_neg   = op_q[1] ? negr_q : negq_q;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    always_comb begin
        alu_req   = 1'b0;
        alu_rs1   = '0;
        alu_b     = '0;
        alu_alufn = ALUFN_ADD;
        unique case (state_q)
            S_ABS_A: begin
                alu_req = 1'b1;
                if (~op_q[0] & a_q[XLEN-1]) begin
                    alu_b     = a_q;
                    alu_alufn = ALUFN_SUB;
                end else begin
                    alu_rs1 = a_q;
                end
            end
            S_ABS_B: begin
                alu_req = 1'b1;
                if (~op_q[0] & b_q[XLEN-1]) begin
                    alu_b     = b_q;
                    alu_alufn = ALUFN_SUB;
                end else begin
                    alu_rs1 = b_q;
                end
            end
            S_DIV: begin
                alu_req   = 1'b1;
                alu_rs1   = sh;
                alu_b     = dsr_q;
                alu_alufn = ALUFN_SUB;
            end
            S_SIGN: begin
                alu_req = 1'b1;
                if (sel_neg) begin
                    alu_b     = sel_v;
                    alu_alufn = ALUFN_SUB;
                end else begin
                    alu_rs1 = sel_v;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        a_q    <= dividend;
                        b_q    <= divisor;
                        negq_q <= in_signed
                                & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        negr_q <= in_signed & dividend[XLEN-1];
                        busy_q <= 1'b1;
                        if (divisor == '0) begin
                            result_q <= op[1] ? dividend : ALL_ONE;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (in_signed & (dividend == MIN_NEG)
                                   & (divisor == ALL_ONE)) begin
                            result_q <= op[1] ? '0 : MIN_NEG;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_ABS_A;
                        end
                    end
                end
                S_ABS_A: begin
                    quo_q   <= alu_r;
                    state_q <= S_ABS_B;
                end
                S_ABS_B: begin
                    dsr_q   <= alu_r;
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_DIV;
                end
                S_DIV: begin
                    rem_q <= acc ? alu_r : sh;
                    quo_q <= {quo_q[XLEN-2:0], acc};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST) begin
                        state_q <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    result_q <= alu_r;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_alu_sequencer.sv
// Directed bench for div_alu_sequencer with a behavioural shared ALU.
// Expected quotients/remainders are hand-computed constants.
module tb_div_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_req;
    logic [31:0] alu_rs1;
    logic [31:0] alu_b;
    logic [3:0]  alu_alufn;
    logic [31:0] alu_r;
    logic        alu_cf;
    logic [32:0] sum;

    int errors;
    int checks;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    div_alu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .alu_req   (alu_req),
        .alu_rs1   (alu_rs1),
        .alu_b     (alu_b),
        .alu_alufn (alu_alufn),
        .alu_r     (alu_r),
        .alu_cf    (alu_cf)
    );

    // Shared ALU: cf on SUB is the no-borrow flag.
    always_comb begin
        if (alu_alufn == 4'b0001)
            sum = {1'b0, alu_rs1} + {1'b0, ~alu_b} + 33'd1;
        else
            sum = {1'b0, alu_rs1} + {1'b0, alu_b};
    end
    assign alu_r  = sum[31:0];
    assign alu_cf = sum[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Launch one op, wait for done, check result and latency.
    // poke: pulse a start mid-operation and hold one in DONE.
    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat,
                       input bit poke);
        int k;
        bit seen_req;
        bit got_done;
        seen_req = 1'b0;
        got_done = 1'b0;
        @(negedge clk);
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (alu_req) seen_req = 1'b1;
            if (!alu_req && (alu_rs1 != 0 || alu_b != 0))
                check({tag, " idle_alu"}, {alu_rs1 | alu_b}, 32'd0);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (poke && k == 5) begin
                op = DIVU; dividend = 32'd50; divisor = 32'd0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, " done"}, 32'(got_done), 32'd1);
        check({tag, " lat"}, k, lat);
        check({tag, " res"}, result, exp);
        check({tag, " busy@done"}, 32'(busy), 32'd1);
        if (lat == 1)
            check({tag, " fast_req"}, 32'(seen_req), 32'd0);
        if (poke) begin
            op = DIVU; dividend = 32'd1; divisor = 32'd0;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
        check({tag, " hold"}, result, exp);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        start = 1'b0; op = 2'b00;
        dividend = '0; divisor = '0;
        rst = 1'b1;
        #12;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        check("rst alu_req", 32'(alu_req), 32'd0);
        check("rst alufn", 32'(alu_alufn), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 36, 1'b0);
        run("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 36, 1'b0);
        run("div -7/2", DIV, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFD, 36, 1'b0);
        run("rem -7/2", REM, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 36, 1'b0);
        run("div 7/-2", DIV, 32'd7, 32'hFFFFFFFE,
            32'hFFFFFFFD, 36, 1'b0);
        run("rem 7/-2", REM, 32'd7, 32'hFFFFFFFE, 32'd1, 36, 1'b0);
        run("divu 5/0", DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
        run("remu 5/0", REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 1, 1'b0);
        run("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF,
            32'd0, 1, 1'b0);
        run("divu top", DIVU, 32'hFFFFFFFF, 32'h80000001,
            32'd1, 36, 1'b0);
        run("remu top", REMU, 32'hFFFFFFFF, 32'h80000001,
            32'h7FFFFFFE, 36, 1'b0);
        run("div min/2", DIV, 32'h80000000, 32'd2,
            32'hC0000000, 36, 1'b0);

        // Reset in the middle of an operation.
        @(negedge clk);
        op = DIVU; dividend = 32'd1000; divisor = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst req", 32'(alu_req), 32'd0);
        check("midrst result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("divu 9/3 poke", DIVU, 32'd9, 32'd3, 32'd3, 36, 1'b1);
        run("remu 9/3", REMU, 32'd9, 32'd3, 32'd0, 36, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
